// File: rtl/superbank_req_pipe_decoder.sv
// Routes one wide DMA port onto NrSuperBanks TCDM superbanks. Supports two address
// interleave modes, an optional one-entry request register and an out-of-range error
// path. Every accepted request gets exactly one response after MemoryLatency cycles.
module superbank_req_pipe_decoder #(
  parameter int unsigned TCDMAddrWidth  = 10,
  parameter int unsigned DMAAddrWidth   = 32,
  parameter int unsigned NrSuperBanks   = 4,
  parameter int unsigned DMADataWidth   = 512,
  parameter int unsigned AmoWidth       = 6,
  parameter int unsigned MemoryLatency  = 1,
  parameter int unsigned InterleaveMode = 0,
  parameter int unsigned ReqRegister    = 0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         dma_req_i,
  output logic                                         dma_gnt_o,
  input  logic [DMAAddrWidth-1:0]                      dma_add_i,
  input  logic [AmoWidth-1:0]                          dma_amo_i,
  input  logic                                         dma_wen_i,
  input  logic [DMADataWidth-1:0]                      dma_wdata_i,
  input  logic [DMADataWidth/8-1:0]                    dma_be_i,
  output logic [DMADataWidth-1:0]                      dma_rdata_o,
  output logic                                         dma_rvalid_o,
  output logic                                         dma_rerr_o,
  output logic [NrSuperBanks-1:0]                      super_bank_req_o,
  input  logic [NrSuperBanks-1:0]                      super_bank_gnt_i,
  output logic [NrSuperBanks-1:0][TCDMAddrWidth-1:0]   super_bank_add_o,
  output logic [NrSuperBanks-1:0][AmoWidth-1:0]        super_bank_amo_o,
  output logic [NrSuperBanks-1:0]                      super_bank_wen_o,
  output logic [NrSuperBanks-1:0][DMADataWidth-1:0]    super_bank_wdata_o,
  output logic [NrSuperBanks-1:0][DMADataWidth/8-1:0]  super_bank_be_o,
  input  logic [NrSuperBanks-1:0][DMADataWidth-1:0]    super_bank_rdata_i
);

  localparam int unsigned NB = $clog2(DMADataWidth / 8);
  localparam int unsigned SB = $clog2(NrSuperBanks);
  localparam int unsigned T  = TCDMAddrWidth;
  localparam int unsigned BeWidth = DMADataWidth / 8;

  // Address decode of the incoming request
  logic [SB-1:0] dec_bank;
  logic [T-1:0]  dec_line;
  logic          dec_err;

  if (InterleaveMode == 0) begin : g_interleaved
    assign dec_bank = dma_add_i[NB+SB-1:NB];
    assign dec_line = dma_add_i[NB+SB+T-1:NB+SB];
  end else begin : g_contiguous
    assign dec_line = dma_add_i[NB+T-1:NB];
    assign dec_bank = dma_add_i[NB+T+SB-1:NB+T];
  end

  if (DMAAddrWidth > NB + SB + T) begin : g_range_chk
    assign dec_err = |dma_add_i[DMAAddrWidth-1:NB+SB+T];
  end else begin : g_no_range_chk
    assign dec_err = 1'b0;
  end

  // Byte offset within a line never affects routing
  logic unused_add_lsb;
  assign unused_add_lsb = ^dma_add_i[NB-1:0];

  // Request as presented to the bank side, plus the accept event feeding the pipeline
  logic                    out_valid;
  logic                    out_err;
  logic [SB-1:0]           out_bank;
  logic [T-1:0]            out_line;
  logic [AmoWidth-1:0]     out_amo;
  logic                    out_wen;
  logic [DMADataWidth-1:0] out_wdata;
  logic [BeWidth-1:0]      out_be;
  logic                    accept;

  if (ReqRegister == 0) begin : g_direct
    assign out_valid = dma_req_i;
    assign out_err   = dec_err;
    assign out_bank  = dec_bank;
    assign out_line  = dec_line;
    assign out_amo   = dma_amo_i;
    assign out_wen   = dma_wen_i;
    assign out_wdata = dma_wdata_i;
    assign out_be    = dma_be_i;
    // Error requests never reach a bank, so they are granted unconditionally
    assign dma_gnt_o = dec_err | super_bank_gnt_i[dec_bank];
    assign accept    = dma_req_i & dma_gnt_o;
  end else begin : g_registered
    logic                    valid_q;
    logic                    err_q;
    logic [SB-1:0]           bank_q;
    logic [T-1:0]            line_q;
    logic [AmoWidth-1:0]     amo_q;
    logic                    wen_q;
    logic [DMADataWidth-1:0] wdata_q;
    logic [BeWidth-1:0]      be_q;
    logic                    fwd;
    logic                    load;

    assign fwd       = valid_q & (err_q | super_bank_gnt_i[bank_q]);
    // Load and unload may coincide, sustaining one request per cycle
    assign dma_gnt_o = ~valid_q | fwd;
    assign load      = dma_req_i & dma_gnt_o;

    // One-entry request register; fields only change on load so they hold while stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        bank_q  <= '0;
        line_q  <= '0;
        amo_q   <= '0;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        be_q    <= '0;
      end else if (load) begin
        valid_q <= 1'b1;
        err_q   <= dec_err;
        bank_q  <= dec_bank;
        line_q  <= dec_line;
        amo_q   <= dma_amo_i;
        wen_q   <= dma_wen_i;
        wdata_q <= dma_wdata_i;
        be_q    <= dma_be_i;
      end else if (fwd) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid = valid_q;
    assign out_err   = err_q;
    assign out_bank  = bank_q;
    assign out_line  = line_q;
    assign out_amo   = amo_q;
    assign out_wen   = wen_q;
    assign out_wdata = wdata_q;
    assign out_be    = be_q;
    assign accept    = fwd;
  end

  // Steer the request to the selected bank only; every other bank sees all-zero fields
  always_comb begin
    super_bank_req_o   = '0;
    super_bank_add_o   = '0;
    super_bank_amo_o   = '0;
    super_bank_wen_o   = '0;
    super_bank_wdata_o = '0;
    super_bank_be_o    = '0;
    if (out_valid && !out_err) begin
      super_bank_req_o[out_bank]   = 1'b1;
      super_bank_add_o[out_bank]   = out_line;
      super_bank_amo_o[out_bank]   = out_amo;
      super_bank_wen_o[out_bank]   = out_wen;
      super_bank_wdata_o[out_bank] = out_wdata;
      super_bank_be_o[out_bank]    = out_be;
    end
  end

  // Response tracking pipeline, one stage per cycle of bank read latency
  logic [MemoryLatency-1:0]         pipe_valid_q;
  logic [MemoryLatency-1:0]         pipe_err_q;
  logic [MemoryLatency-1:0][SB-1:0] pipe_bank_q;

  // Shift accepted requests towards the response port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      pipe_bank_q  <= '0;
    end else begin
      pipe_valid_q[0] <= accept;
      pipe_err_q[0]   <= out_err;
      pipe_bank_q[0]  <= out_bank;
      for (int unsigned i = 1; i < MemoryLatency; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
        pipe_bank_q[i]  <= pipe_bank_q[i-1];
      end
    end
  end

  // Response from the last stage; error responses carry zero data
  always_comb begin
    dma_rvalid_o = pipe_valid_q[MemoryLatency-1];
    dma_rerr_o   = pipe_valid_q[MemoryLatency-1] & pipe_err_q[MemoryLatency-1];
    dma_rdata_o  = '0;
    if (pipe_valid_q[MemoryLatency-1] && !pipe_err_q[MemoryLatency-1]) begin
      dma_rdata_o = super_bank_rdata_i[pipe_bank_q[MemoryLatency-1]];
    end
  end

endmodule

// File: tb/tb_superbank_req_pipe_decoder.sv
// Bench for superbank_req_pipe_decoder: three parameter lanes, each with a driver,
// a bank model, a spec-level reference model and a scoreboard monitor.
module tb_superbank_req_pipe_decoder;

  typedef struct {
    bit              err;
    logic [511:0]    data;
  } rsp_t;

  typedef struct {
    int              bank;
    int              line;
    logic [5:0]      amo;
    logic            wen;
    logic [511:0]    wdata;
    logic [63:0]     be;
  } breq_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lanes_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int lane, input bit ok, input string nm,
                     input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lane%0d %s: got %0h expected %0h (cycle %0d)", lane, nm, act, exp, cyc);
    end
  endtask

  // Reference decode from plain arithmetic on the line offset
  function automatic void decode(input int unsigned mode, input logic [31:0] a,
                                 output int bank, output int line, output bit err);
    longint off;
    off  = longint'(a) / 64;
    err  = off >= 4096;
    if (mode == 0) begin
      bank = int'(off % 4);
      line = int'((off / 4) % 1024);
    end else begin
      line = int'(off % 1024);
      bank = int'((off / 1024) % 4);
    end
  endfunction

  // Content a bank returns for a given line
  function automatic logic [511:0] bank_word(input int b, input int line);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) begin
      w[i*32 +: 32] = (32'(b) * 32'h0100_0193) ^ (32'(line) * 32'h9E37_79B1) ^
                      (32'(i) * 32'h0001_0001) ^ 32'hC0DE_0000;
    end
    return w;
  endfunction

  for (genvar L = 0; L < 3; L++) begin : g_lane
    localparam int unsigned Mode = (L == 1) ? 1 : 0;
    localparam int unsigned RR   = (L == 0) ? 0 : 1;
    localparam int unsigned ML   = (L == 0) ? 1 : ((L == 1) ? 3 : 2);

    logic                 rst = 1'b1;
    logic                 dma_req = 1'b0;
    logic                 dma_gnt;
    logic [31:0]          dma_add = '0;
    logic [5:0]           dma_amo = '0;
    logic                 dma_wen = 1'b0;
    logic [511:0]         dma_wdata = '0;
    logic [63:0]          dma_be = '0;
    logic [511:0]         dma_rdata;
    logic                 dma_rvalid;
    logic                 dma_rerr;
    logic [3:0]           sb_req;
    logic [3:0]           sb_gnt = 4'hF;
    logic [3:0][9:0]      sb_add;
    logic [3:0][5:0]      sb_amo;
    logic [3:0]           sb_wen;
    logic [3:0][511:0]    sb_wdata;
    logic [3:0][63:0]     sb_be;
    logic [3:0][511:0]    sb_rdata = '0;

    rsp_t  rq[$];
    breq_t bq[$];
    int    cq[$];
    bit    rand_gnt = 1'b0;
    logic [3:0] force_low = 4'h0;
    bit    hv[4][8];
    int    hl[4][8];

    superbank_req_pipe_decoder #(
      .MemoryLatency  (ML),
      .InterleaveMode (Mode),
      .ReqRegister    (RR)
    ) u_dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .dma_req_i          (dma_req),
      .dma_gnt_o          (dma_gnt),
      .dma_add_i          (dma_add),
      .dma_amo_i          (dma_amo),
      .dma_wen_i          (dma_wen),
      .dma_wdata_i        (dma_wdata),
      .dma_be_i           (dma_be),
      .dma_rdata_o        (dma_rdata),
      .dma_rvalid_o       (dma_rvalid),
      .dma_rerr_o         (dma_rerr),
      .super_bank_req_o   (sb_req),
      .super_bank_gnt_i   (sb_gnt),
      .super_bank_add_o   (sb_add),
      .super_bank_amo_o   (sb_amo),
      .super_bank_wen_o   (sb_wen),
      .super_bank_wdata_o (sb_wdata),
      .super_bank_be_o    (sb_be),
      .super_bank_rdata_i (sb_rdata)
    );

    // Bank model: grants and read data ML cycles after each bank handshake
    always @(posedge clk) begin
      int s;
      #1;
      s = (cyc - int'(ML)) & 7;
      for (int b = 0; b < 4; b++) begin
        sb_gnt[b] = rand_gnt ? ($urandom_range(0, 99) < 70) : 1'b1;
        if (force_low[b]) sb_gnt[b] = 1'b0;
        if (hv[b][s]) sb_rdata[b] = bank_word(b, hl[b][s]);
        else for (int i = 0; i < 16; i++) sb_rdata[b][i*32 +: 32] = $urandom;
      end
    end

    // Reference model: grant rule, request-register occupancy, expected response cycles
    bit held = 1'b0, held_err = 1'b0, prev_err_hs = 1'b0;
    int held_bank = 0;
    always @(negedge clk) begin
      int mb, ml;
      bit me, hs, acc, fwd;
      logic eg;
      decode(Mode, dma_add, mb, ml, me);
      if (rst) begin
        held = 1'b0;
        prev_err_hs = 1'b0;
        cq.delete();
      end
      if (RR == 0) eg = me ? 1'b1 : sb_gnt[mb];
      else eg = !held || held_err || sb_gnt[held_bank];
      chk(L, dma_gnt === eg, "dma_gnt", 640'(dma_gnt), 640'(eg));
      if (!rst) begin
        hs = dma_req && dma_gnt;
        if (RR == 0) acc = hs;
        else acc = (|(sb_req & sb_gnt)) || prev_err_hs;
        if (acc) cq.push_back(cyc + int'(ML));
        if (RR != 0) begin
          fwd = held && (held_err || sb_gnt[held_bank]);
          prev_err_hs = hs && me;
          if (hs) begin
            held = 1'b1;
            held_err = me;
            held_bank = mb;
          end else if (fwd) begin
            held = 1'b0;
          end
        end
      end
    end

    // Monitor: response scoreboard, response timing, bank-side fields
    logic [3:0] pst = '0;
    logic [3:0][593:0] pf;
    always @(negedge clk) begin
      bit due;
      rsp_t r;
      breq_t e;
      logic [593:0] f, ef;
      if (rst) begin
        chk(L, dma_rvalid === 1'b0, "rst_rvalid", 640'(dma_rvalid), 640'(0));
        chk(L, dma_rerr === 1'b0, "rst_rerr", 640'(dma_rerr), 640'(0));
        chk(L, dma_rdata === '0, "rst_rdata", 640'(dma_rdata), 640'(0));
        chk(L, sb_req === 4'h0, "rst_sb_req", 640'(sb_req), 640'(0));
        pst = '0;
        for (int b = 0; b < 4; b++) hv[b][cyc & 7] = 1'b0;
      end else begin
        due = (cq.size() > 0) && (cq[0] == cyc);
        if (dma_rvalid || due) chk(L, dma_rvalid === due, "rvalid_timing",
                                   640'(dma_rvalid), 640'(due));
        if (due) void'(cq.pop_front());
        if (dma_rvalid === 1'b1) begin
          if (rq.size() == 0) begin
            chk(L, 1'b0, "unexpected_rvalid", 640'(1), 640'(0));
          end else begin
            r = rq.pop_front();
            chk(L, dma_rerr === r.err, "rerr", 640'(dma_rerr), 640'(r.err));
            chk(L, dma_rdata === r.data, "rdata", 640'(dma_rdata), 640'(r.data));
          end
        end
        if (sb_req != 4'h0) chk(L, $countones(sb_req) <= 1, "sb_req_onehot",
                                640'(sb_req), 640'(0));
        for (int b = 0; b < 4; b++) begin
          f = {sb_req[b], sb_add[b], sb_amo[b], sb_wen[b], sb_wdata[b], sb_be[b]};
          if (!sb_req[b]) begin
            chk(L, f === '0, $sformatf("idle_bank%0d_zero", b), 640'(f), 640'(0));
          end else if (bq.size() == 0) begin
            chk(L, 1'b0, $sformatf("unexpected_req_bank%0d", b), 640'(f), 640'(0));
          end else begin
            e = bq[0];
            ef = {1'b1, 10'(e.line), e.amo, e.wen, e.wdata, e.be};
            chk(L, b == e.bank, "bank_select", 640'(b), 640'(e.bank));
            chk(L, f === ef, "bank_fields", 640'(f), 640'(ef));
            if (sb_gnt[b]) void'(bq.pop_front());
          end
          if (pst[b]) chk(L, f === pf[b], "stall_hold", 640'(f), 640'(pf[b]));
          pf[b] = f;
          hv[b][cyc & 7] = sb_req[b] && sb_gnt[b];
          hl[b][cyc & 7] = int'(sb_add[b]);
        end
        pst = sb_req & ~sb_gnt;
      end
    end

    // Present one request and wait (bounded) for the DMA handshake
    task automatic issue(input logic [31:0] a, input logic w);
      int b, l;
      bit e, got;
      breq_t br;
      rsp_t r;
      decode(Mode, a, b, l, e);
      dma_add = a;
      dma_wen = w;
      dma_amo = 6'($urandom);
      for (int i = 0; i < 16; i++) dma_wdata[i*32 +: 32] = $urandom;
      dma_be = {$urandom, $urandom};
      if (!e) begin
        br.bank = b; br.line = l; br.amo = dma_amo; br.wen = w;
        br.wdata = dma_wdata; br.be = dma_be;
        bq.push_back(br);
      end
      dma_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
        @(negedge clk);
        got = dma_gnt;
      end
      if (got) begin
        r.err = e;
        if (e) r.data = '0;
        else r.data = bank_word(b, l);
        rq.push_back(r);
      end else begin
        chk(L, 1'b0, "gnt_timeout", 640'(0), 640'(1));
      end
      @(posedge clk);
      #1;
      dma_req = 1'b0;
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    function automatic logic [31:0] bank_addr(input int b);
      return (Mode == 0) ? 32'(b * 64) : 32'(b) << 16;
    endfunction

    // Driver
    initial begin
      idle(3);
      rst = 1'b0;
      idle(1);
      issue(32'h0000_0140, 1'b0);
      issue(32'h0002_8040, 1'b1);
      issue(32'h0004_0000, 1'b0);
      idle(4);
      for (int b = 0; b < 4; b++) issue(bank_addr(b), 1'b0);
      idle(6);
      // Bank 2 refuses for three cycles while a second request queues behind it
      force_low = 4'b0100;
      idle(1);
      fork
        begin
          repeat (3) @(posedge clk);
          force_low = 4'h0;
        end
      join_none
      issue(bank_addr(2), 1'b1);
      issue(bank_addr(1), 1'b0);
      idle(6);
      rand_gnt = 1'b1;
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(0, 9) == 0) issue($urandom | 32'h0004_0000, 1'(($urandom)));
        else issue($urandom & 32'h0003_FFFF, 1'($urandom));
        idle($urandom_range(0, 2));
      end
      rand_gnt = 1'b0;
      idle(8);
      issue(bank_addr(3), 1'b0);
      issue(bank_addr(0), 1'b0);
      rst = 1'b1;
      rq.delete();
      bq.delete();
      idle(2);
      rst = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk(L, dma_rvalid === 1'b0, "post_reset_rvalid", 640'(dma_rvalid), 640'(0));
      end
      idle(1);
      issue(32'h0000_0140, 1'b0);
      for (int k = 0; k < 50 && (rq.size() > 0); k++) idle(1);
      idle(2);
      chk(L, rq.size() == 0, "drain_rsp", 640'(rq.size()), 640'(0));
      chk(L, bq.size() == 0, "drain_bank", 640'(bq.size()), 640'(0));
      lanes_done++;
    end
  end

  initial begin
    wait (lanes_done == 3);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL global_timeout: got %0d lanes done expected 3", lanes_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
